// File: rtl/i_cache_axi_rd_pkg.sv
// Shared AXI field encodings, FSM state encoding and address helper for the
// I-cache refill read master.
package i_cache_axi_rd_pkg;

  localparam logic [2:0] ysyx22040228_AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] ysyx22040228_AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] ysyx22040228_AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] AXI_LEN_SINGLE              = 8'd0;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_AR   = 4'b0010,
    ST_R    = 4'b0100,
    ST_OK   = 4'b1000
  } rd_state_e;

  // Refills are whole 64-bit words, so the byte offset is always dropped.
  function automatic logic [63:0] align8(input logic [63:0] a);
    return a & ~64'h7;
  endfunction

endpackage

// File: rtl/i_cache_axi_rd_hold_cnt.sv
// 3-bit load/decrement counter that times the refill OK window; o_last marks
// the final cycle of the window.
module axi_rd_hold_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [2:0] i_load_val,
  input  logic       i_dec,
  output logic       o_last
);

  logic [2:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_dec && r_cnt != 3'd0)
      r_cnt <= r_cnt - 3'd1;
  end

  assign o_last = (r_cnt == 3'd1);

endmodule

// File: rtl/i_cache_axi_rd.sv
// I-cache refill read master: turns a level-held refill request into one
// single-beat AXI4 read and presents the word for a fixed OK window.
module i_cache_axi_rd
  import i_cache_axi_rd_pkg::*;
#(
  parameter logic [3:0]  AXI_ID  = 4'd0,
  parameter int unsigned OK_HOLD = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_read_ena,
  input  logic [63:0] cache_addr,
  output logic [63:0] cache_or_data,
  output logic        cache_in_ok,
  output logic        axi_working_ti,
  output logic        rd_err,
  output logic        axi_ar_valid_o,
  input  logic        axi_ar_ready_i,
  output logic [63:0] axi_ar_addr_o,
  output logic [3:0]  axi_ar_id_o,
  output logic [7:0]  axi_ar_len_o,
  output logic [2:0]  axi_ar_size_o,
  output logic [1:0]  axi_ar_burst_o,
  input  logic        axi_r_valid_i,
  output logic        axi_r_ready_o,
  input  logic [63:0] axi_r_data_i,
  input  logic [1:0]  axi_r_resp_i,
  input  logic        axi_r_last_i,
  input  logic [3:0]  axi_r_id_i
);

  rd_state_e   r_state;
  logic [63:0] r_addr_q;
  logic [63:0] r_data;
  logic        r_err;
  logic        r_beat_seen;

  logic w_beat;
  logic w_load;
  logic w_ok_last;

  assign w_beat = axi_r_valid_i && (axi_r_id_i == AXI_ID);
  // Only the first matching beat loads data and the window length.
  assign w_load = (r_state == ST_R) && w_beat && !r_beat_seen;

  axi_rd_hold_cnt u_hold_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (3'(OK_HOLD)),
    .i_dec      (r_state == ST_OK),
    .o_last     (w_ok_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_addr_q    <= '0;
      r_data      <= '0;
      r_err       <= 1'b0;
      r_beat_seen <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cache_read_ena) begin
            r_addr_q <= align8(cache_addr);
            r_state  <= ST_AR;
          end
        end
        ST_AR: begin
          if (axi_ar_ready_i) begin
            r_beat_seen <= 1'b0;
            r_state     <= ST_R;
          end
        end
        ST_R: begin
          if (w_beat) begin
            if (!r_beat_seen) begin
              r_data      <= axi_r_data_i;
              r_err       <= (axi_r_resp_i != ysyx22040228_AXI_RESP_OKAY);
              r_beat_seen <= 1'b1;
            end
            if (axi_r_last_i)
              r_state <= ST_OK;
          end
        end
        ST_OK: begin
          // A request re-raised during the fill window is deliberately ignored.
          if (w_ok_last)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign axi_ar_valid_o = (r_state == ST_AR);
  assign axi_ar_addr_o  = r_addr_q;
  assign axi_ar_id_o    = AXI_ID;
  assign axi_ar_len_o   = AXI_LEN_SINGLE;
  assign axi_ar_size_o  = ysyx22040228_AXI_SIZE_8B;
  assign axi_ar_burst_o = ysyx22040228_AXI_BURST_INCR;
  assign axi_r_ready_o  = (r_state == ST_R);
  assign cache_in_ok    = (r_state == ST_OK);
  assign rd_err         = (r_state == ST_OK) && r_err;
  assign axi_working_ti = (r_state != ST_IDLE);
  assign cache_or_data  = r_data;

endmodule

// File: tb/tb_i_cache_axi_rd.sv
// Scenario bench for i_cache_axi_rd: an AXI slave driver plus a cycle-count
// reference model derived from the refill timing rules.
module tb_i_cache_axi_rd;

  localparam logic [3:0] TB_ID   = 4'd5;
  localparam int         TB_HOLD = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_read_ena;
  logic [63:0] cache_addr;
  logic [63:0] cache_or_data;
  logic        cache_in_ok, axi_working_ti, rd_err;
  logic        axi_ar_valid_o, axi_ar_ready_i;
  logic [63:0] axi_ar_addr_o;
  logic [3:0]  axi_ar_id_o;
  logic [7:0]  axi_ar_len_o;
  logic [2:0]  axi_ar_size_o;
  logic [1:0]  axi_ar_burst_o;
  logic        axi_r_valid_i, axi_r_ready_o;
  logic [63:0] axi_r_data_i;
  logic [1:0]  axi_r_resp_i;
  logic        axi_r_last_i;
  logic [3:0]  axi_r_id_i;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  i_cache_axi_rd #(.AXI_ID(TB_ID), .OK_HOLD(TB_HOLD)) dut (
    .clk            (clk),
    .rst            (rst),
    .cache_read_ena (cache_read_ena),
    .cache_addr     (cache_addr),
    .cache_or_data  (cache_or_data),
    .cache_in_ok    (cache_in_ok),
    .axi_working_ti (axi_working_ti),
    .rd_err         (rd_err),
    .axi_ar_valid_o (axi_ar_valid_o),
    .axi_ar_ready_i (axi_ar_ready_i),
    .axi_ar_addr_o  (axi_ar_addr_o),
    .axi_ar_id_o    (axi_ar_id_o),
    .axi_ar_len_o   (axi_ar_len_o),
    .axi_ar_size_o  (axi_ar_size_o),
    .axi_ar_burst_o (axi_ar_burst_o),
    .axi_r_valid_i  (axi_r_valid_i),
    .axi_r_ready_o  (axi_r_ready_o),
    .axi_r_data_i   (axi_r_data_i),
    .axi_r_resp_i   (axi_r_resp_i),
    .axi_r_last_i   (axi_r_last_i),
    .axi_r_id_i     (axi_r_id_i)
  );

  typedef struct {
    int          ar_hs, first_ok, ok_cnt, work_cnt, rready_cnt;
    logic [63:0] araddr, ok_data;
    logic        ok_err;
    bit          ar_bad, ok_unstable, ar_during_ok, timeout;
  } obs_t;

  typedef struct {
    int          ar_hs, first_ok, ok_cnt, work_cnt, rready_cnt;
    logic [63:0] araddr, data;
    logic        err;
  } exp_t;

  // Reference timing: request seen in cycle 0, one cycle per AR/R attempt,
  // each extra beat adds a cycle, then OK_HOLD cycles of valid data.
  function automatic exp_t model(logic [63:0] addr, int ar_stall, int r_stall,
                                 bit stray, bit missing, logic [63:0] da,
                                 logic [1:0] resp);
    exp_t e;
    int   r_last;
    e.ar_hs      = 1 + ar_stall;
    r_last       = e.ar_hs + 1 + r_stall + int'(stray) + int'(missing);
    e.first_ok   = r_last + 1;
    e.ok_cnt     = TB_HOLD;
    e.work_cnt   = e.first_ok + TB_HOLD - 1;
    e.rready_cnt = r_last - e.ar_hs;
    e.araddr     = {addr[63:3], 3'b000};
    e.data       = da;
    e.err        = (resp != 2'b00);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cache_read_ena = 1'b0;
    axi_ar_ready_i = 1'b0;
    axi_r_valid_i  = 1'b0;
    axi_r_data_i   = '0;
    axi_r_resp_i   = 2'b00;
    axi_r_last_i   = 1'b0;
    axi_r_id_i     = TB_ID;
  endtask

  // Plays one refill as cache + AXI slave and records what the DUT did.
  // Returns in the first cycle after the OK window, without advancing time.
  task automatic run_txn(input logic [63:0] addr, input int ar_stall,
                         input int r_stall, input bit stray, input bit missing,
                         input bit reraise, input logic [63:0] da,
                         input logic [63:0] db, input logic [1:0] resp,
                         output obs_t o);
    int  n_ar = 0;
    int  k;
    int  k0   = r_stall + int'(stray);
    bit  done = 0;
    o = '{ar_hs: -1, first_ok: -1, default: 0};
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (axi_working_ti) o.work_cnt++;
      if (cache_in_ok) begin
        if (o.ok_cnt == 0) begin
          o.first_ok = cyc;
          o.ok_data  = cache_or_data;
          o.ok_err   = rd_err;
        end else if (cache_or_data !== o.ok_data || rd_err !== o.ok_err) begin
          o.ok_unstable = 1;
        end
        if (axi_ar_valid_o) o.ar_during_ok = 1;
        o.ok_cnt++;
      end else if (o.ok_cnt > 0) begin
        done = 1;
      end
      idle_inputs();
      if (done) begin
        cache_read_ena = reraise;
        break;
      end
      cache_read_ena = (cyc == 0) || (reraise && cache_in_ok);
      cache_addr     = (cyc == 0) ? addr : {$urandom, $urandom};
      axi_r_data_i   = {$urandom, $urandom};
      if (axi_ar_valid_o) begin
        if (n_ar == 0) o.araddr = axi_ar_addr_o;
        else if (axi_ar_addr_o !== o.araddr) o.ar_bad = 1;
        if (axi_ar_len_o !== 8'd0 || axi_ar_size_o !== 3'b011 ||
            axi_ar_burst_o !== 2'b01 || axi_ar_id_o !== TB_ID) o.ar_bad = 1;
        if (n_ar == ar_stall) begin
          axi_ar_ready_i = 1'b1;
          o.ar_hs        = cyc;
        end
        n_ar++;
      end
      if (axi_r_ready_o) begin
        k = o.rready_cnt;
        o.rready_cnt++;
        if (stray && k == r_stall) begin
          axi_r_valid_i = 1'b1;
          axi_r_id_i    = TB_ID ^ 4'h9;
          axi_r_last_i  = 1'b1;
        end else if (k == k0) begin
          axi_r_valid_i = 1'b1;
          axi_r_data_i  = da;
          axi_r_resp_i  = resp;
          axi_r_last_i  = !missing;
        end else if (missing && k == k0 + 1) begin
          axi_r_valid_i = 1'b1;
          axi_r_data_i  = db;
          axi_r_resp_i  = ~resp;
          axi_r_last_i  = 1'b1;
        end
      end
      tick();
    end
    if (!done) o.timeout = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    cache_addr = '0;
    tick();
    tick();
    n_chk++; if (cache_or_data !== 64'd0) $display("FAIL rst_data got %h exp 0", cache_or_data); else n_pass++;
    n_chk++; if (cache_in_ok !== 1'b0) $display("FAIL rst_ok got %b exp 0", cache_in_ok); else n_pass++;
    n_chk++; if (axi_working_ti !== 1'b0) $display("FAIL rst_working got %b exp 0", axi_working_ti); else n_pass++;
    n_chk++; if (rd_err !== 1'b0) $display("FAIL rst_err got %b exp 0", rd_err); else n_pass++;
    n_chk++; if (axi_ar_valid_o !== 1'b0) $display("FAIL rst_arvalid got %b exp 0", axi_ar_valid_o); else n_pass++;
    n_chk++; if (axi_r_ready_o !== 1'b0) $display("FAIL rst_rready got %b exp 0", axi_r_ready_o); else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait();
    obs_t o;
    exp_t e;
    e = model(64'h8000_0014, 0, 0, 0, 0, 64'h1122_3344_5566_7788, 2'b00);
    run_txn(64'h8000_0014, 0, 0, 0, 0, 0, 64'h1122_3344_5566_7788, '0, 2'b00, o);
    n_chk++; if (o.timeout) $display("FAIL zw_timeout got 1 exp 0"); else n_pass++;
    n_chk++; if (o.araddr !== 64'h8000_0010) $display("FAIL zw_araddr got %h exp 8000_0010", o.araddr); else n_pass++;
    n_chk++; if (o.ar_bad) $display("FAIL zw_ar_fields got bad exp fixed"); else n_pass++;
    n_chk++; if (o.ar_hs != e.ar_hs) $display("FAIL zw_ar_hs got %0d exp %0d", o.ar_hs, e.ar_hs); else n_pass++;
    n_chk++; if (o.first_ok != e.first_ok) $display("FAIL zw_first_ok got %0d exp %0d", o.first_ok, e.first_ok); else n_pass++;
    n_chk++; if (o.ok_cnt != 3) $display("FAIL zw_ok_cnt got %0d exp 3", o.ok_cnt); else n_pass++;
    n_chk++; if (o.ok_data !== 64'h1122_3344_5566_7788) $display("FAIL zw_data got %h exp 1122334455667788", o.ok_data); else n_pass++;
    n_chk++; if (o.ok_err !== 1'b0) $display("FAIL zw_err got %b exp 0", o.ok_err); else n_pass++;
    n_chk++; if (o.work_cnt != 5) $display("FAIL zw_working got %0d exp 5", o.work_cnt); else n_pass++;
    n_chk++; if (cache_or_data !== 64'h1122_3344_5566_7788) $display("FAIL zw_data_held got %h", cache_or_data); else n_pass++;
    tick();
  endtask

  task automatic test_stall();
    obs_t        o;
    exp_t        e;
    logic [63:0] a = {$urandom, $urandom};
    logic [63:0] d = {$urandom, $urandom};
    e = model(a, 7, 10, 0, 0, d, 2'b00);
    run_txn(a, 7, 10, 0, 0, 0, d, '0, 2'b00, o);
    n_chk++; if (o.ar_bad) $display("FAIL st_ar_const got changed exp constant"); else n_pass++;
    n_chk++; if (o.araddr !== e.araddr) $display("FAIL st_araddr got %h exp %h", o.araddr, e.araddr); else n_pass++;
    n_chk++; if (o.ar_hs != 8) $display("FAIL st_ar_hs got %0d exp 8", o.ar_hs); else n_pass++;
    n_chk++; if (o.rready_cnt != e.rready_cnt) $display("FAIL st_rready got %0d exp %0d", o.rready_cnt, e.rready_cnt); else n_pass++;
    n_chk++; if (o.first_ok != e.first_ok) $display("FAIL st_first_ok got %0d exp %0d", o.first_ok, e.first_ok); else n_pass++;
    n_chk++; if (o.ok_data !== d) $display("FAIL st_data got %h exp %h", o.ok_data, d); else n_pass++;
    tick();
  endtask

  task automatic test_err_id();
    obs_t        o;
    logic [63:0] d = {$urandom, $urandom};
    run_txn({$urandom, $urandom}, 1, 2, 1, 0, 0, d, '0, 2'b10, o);
    n_chk++; if (o.ok_err !== 1'b1) $display("FAIL eid_err got %b exp 1", o.ok_err); else n_pass++;
    n_chk++; if (o.ok_unstable) $display("FAIL eid_stable got unstable exp stable"); else n_pass++;
    n_chk++; if (o.ok_data !== d) $display("FAIL eid_data got %h exp %h", o.ok_data, d); else n_pass++;
    n_chk++; if (o.first_ok != model('0, 1, 2, 1, 0, d, 2'b10).first_ok) $display("FAIL eid_first_ok got %0d", o.first_ok); else n_pass++;
    tick();
  endtask

  task automatic test_reraise();
    obs_t        o;
    logic [63:0] d = {$urandom, $urandom};
    run_txn({$urandom, $urandom}, 0, 1, 0, 0, 1, d, '0, 2'b00, o);
    n_chk++; if (o.ar_during_ok) $display("FAIL rr_ar_in_ok got 1 exp 0"); else n_pass++;
    n_chk++; if (axi_working_ti !== 1'b0) $display("FAIL rr_idle_working got %b exp 0", axi_working_ti); else n_pass++;
    n_chk++; if (axi_ar_valid_o !== 1'b0) $display("FAIL rr_idle_arvalid got %b exp 0", axi_ar_valid_o); else n_pass++;
    d = {$urandom, $urandom};
    run_txn({$urandom, $urandom}, 0, 0, 0, 0, 0, d, '0, 2'b00, o);
    n_chk++; if (o.ar_hs != 1) $display("FAIL rr_next_ar got %0d exp 1", o.ar_hs); else n_pass++;
    n_chk++; if (o.ok_data !== d) $display("FAIL rr_next_data got %h exp %h", o.ok_data, d); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    obs_t        o;
    int          n_ok = 0;
    logic [63:0] d    = {$urandom, $urandom};
    idle_inputs();
    cache_read_ena = 1'b1;
    cache_addr     = {$urandom, $urandom};
    tick();
    cache_read_ena = 1'b0;
    axi_ar_ready_i = 1'b1;
    tick();
    axi_ar_ready_i = 1'b0;
    n_chk++; if (axi_r_ready_o !== 1'b1) $display("FAIL rm_in_r got %b exp 1", axi_r_ready_o); else n_pass++;
    rst           = 1'b0;
    axi_r_valid_i = 1'b1;
    axi_r_data_i  = {$urandom, $urandom};
    axi_r_last_i  = 1'b1;
    tick();
    n_chk++; if (cache_or_data !== 64'd0) $display("FAIL rm_data got %h exp 0", cache_or_data); else n_pass++;
    n_chk++; if (axi_ar_valid_o !== 1'b0) $display("FAIL rm_arvalid got %b exp 0", axi_ar_valid_o); else n_pass++;
    n_chk++; if (axi_r_ready_o !== 1'b0) $display("FAIL rm_rready got %b exp 0", axi_r_ready_o); else n_pass++;
    n_chk++; if (axi_working_ti !== 1'b0) $display("FAIL rm_working got %b exp 0", axi_working_ti); else n_pass++;
    n_chk++; if (cache_in_ok !== 1'b0 || rd_err !== 1'b0) $display("FAIL rm_ok got %b%b exp 00", cache_in_ok, rd_err); else n_pass++;
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      if (cache_in_ok) n_ok++;
      tick();
    end
    n_chk++; if (n_ok != 0) $display("FAIL rm_no_ok got %0d exp 0", n_ok); else n_pass++;
    run_txn({$urandom, $urandom}, 2, 1, 0, 0, 0, d, '0, 2'b00, o);
    n_chk++; if (o.ok_data !== d) $display("FAIL rm_after_data got %h exp %h", o.ok_data, d); else n_pass++;
    n_chk++; if (o.ok_cnt != TB_HOLD) $display("FAIL rm_after_ok got %0d exp %0d", o.ok_cnt, TB_HOLD); else n_pass++;
    tick();
  endtask

  task automatic test_missing_last();
    obs_t        o;
    logic [63:0] da = {$urandom, $urandom};
    logic [63:0] db = ~da;
    run_txn({$urandom, $urandom}, 0, 0, 0, 1, 0, da, db, 2'b00, o);
    n_chk++; if (o.ok_data !== da) $display("FAIL ml_data got %h exp %h", o.ok_data, da); else n_pass++;
    n_chk++; if (o.ok_err !== 1'b0) $display("FAIL ml_err got %b exp 0", o.ok_err); else n_pass++;
    n_chk++; if (o.first_ok != 4) $display("FAIL ml_first_ok got %0d exp 4", o.first_ok); else n_pass++;
    n_chk++; if (o.ok_cnt != TB_HOLD) $display("FAIL ml_ok_cnt got %0d exp %0d", o.ok_cnt, TB_HOLD); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic [63:0] a, da, db;
    logic [1:0]  resp;
    int          ars, rs;
    bit          stray, miss;
    for (int i = 0; i < 10; i++) begin
      a     = {$urandom, $urandom};
      da    = {$urandom, $urandom};
      db    = {$urandom, $urandom};
      resp  = 2'($urandom_range(0, 3));
      ars   = $urandom_range(0, 5);
      rs    = $urandom_range(0, 5);
      stray = 1'($urandom_range(0, 1));
      miss  = 1'($urandom_range(0, 1));
      e     = model(a, ars, rs, stray, miss, da, resp);
      run_txn(a, ars, rs, stray, miss, 0, da, db, resp, o);
      n_chk++; if (o.araddr !== e.araddr || o.ar_bad) $display("FAIL rnd%0d_ar got %h exp %h", i, o.araddr, e.araddr); else n_pass++;
      n_chk++; if (o.first_ok != e.first_ok) $display("FAIL rnd%0d_first_ok got %0d exp %0d", i, o.first_ok, e.first_ok); else n_pass++;
      n_chk++; if (o.work_cnt != e.work_cnt) $display("FAIL rnd%0d_working got %0d exp %0d", i, o.work_cnt, e.work_cnt); else n_pass++;
      n_chk++; if (o.ok_data !== e.data || o.ok_unstable) $display("FAIL rnd%0d_data got %h exp %h", i, o.ok_data, e.data); else n_pass++;
      n_chk++; if (o.ok_err !== e.err) $display("FAIL rnd%0d_err got %b exp %b", i, o.ok_err, e.err); else n_pass++;
      n_chk++; if (o.ok_cnt != e.ok_cnt) $display("FAIL rnd%0d_ok_cnt got %0d exp %0d", i, o.ok_cnt, e.ok_cnt); else n_pass++;
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_err_id();
    test_reraise();
    test_reset_mid();
    test_missing_last();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
